vadd_float_sequencer: RTL
=========================

# vadd_float_sequencer

Run-length sequencer placed between the kernel's AXI4-Stream ports and `vadd_float_adder`. It implements the ap_start/ap_done/ap_idle/ap_ready block protocol for the control slave. For each run it admits exactly `length` beats on each operand stream into the adder. It forwards exactly `length` result beats, generates `tlast` on the final result beat, and flags upstream `tlast` framing errors.

## Interface
Parameters:
- `C_AXIS_TDATA_WIDTH`, 32, stream data width; `tkeep` width is `C_AXIS_TDATA_WIDTH/8`.
- `C_LEN_WIDTH`, 32, width of `length` and of all beat counters.

Ports:
- `ap_aclk`  in  1  clock; all logic on its rising edge.
- `ap_areset`  in  1  reset, synchronous, active-high.
- `ap_start`  in  1  level from the control slave; held until `ap_ready`.
- `length`  in  C_LEN_WIDTH  beats per run; sampled only when a start is accepted.
- `ap_idle`  out  1  high while in IDLE.
- `ap_done`  out  1  one-cycle pulse at end of run.
- `ap_ready`  out  1  equal to `ap_done`.
- `err_tlast`  out  1  sticky upstream framing error; cleared when a start is accepted.
- `s_axis_a_{tvalid,tdata,tkeep,tlast}`  in, with `s_axis_a_tready` out: operand A from the kernel port.
- `s_axis_b_*`  same set as A: operand B from the kernel port.
- `m_axis_a_{tvalid,tdata,tkeep,tlast}`  out, with `m_axis_a_tready` in: operand A toward the adder.
- `m_axis_b_*`  same set as A: operand B toward the adder.
- `s_axis_c_{tvalid,tdata,tkeep,tlast}`  in, with `s_axis_c_tready` out: result from the adder.
- `m_axis_c_{tvalid,tdata,tkeep,tlast}`  out, with `m_axis_c_tready` in: result to the kernel port.

## Operation
- Registers:
  - state ∈ {IDLE, RUN, DONE};
  - `len_r`;
  - counters `cnt_a`, `cnt_b`, `cnt_c` (C_LEN_WIDTH bits each);
  - `err_tlast`.
- IDLE:
  - `ap_start`=1 and `length`≠0: load `len_r`=`length`, zero all counters, clear `err_tlast`, go to RUN.
  - `ap_start`=1 and `length`=0: clear `err_tlast`, go straight to DONE.
- RUN:
  - Gate enables: `en_a` = (`cnt_a` < `len_r`), `en_b` = (`cnt_b` < `len_r`), `en_c` = (`cnt_c` < `len_r`). Each is forced to 0 outside RUN.
  - Operand gating: `m_axis_a_tvalid` = `s_axis_a_tvalid` & `en_a`; `s_axis_a_tready` = `m_axis_a_tready` & `en_a`. B uses the same form with `en_b`.
  - Result gating: `m_axis_c_tvalid` = `s_axis_c_tvalid` & `en_c`; `s_axis_c_tready` = `m_axis_c_tready` & `en_c`.
  - `tdata`/`tkeep` pass through combinationally.
  - `m_axis_a_tlast`/`m_axis_b_tlast` pass upstream `tlast` through.
  - `m_axis_c_tlast` = (`cnt_c` == `len_r`−1). The adder's `tlast` is ignored.
  - Each counter increments by 1 on its gated handshake (valid & ready on the upstream side).
  - A, B and C advance independently; A and B may run ahead of C by the adder's buffering.
  - When the C handshake with `cnt_c` == `len_r`−1 occurs, go to DONE.
- DONE:
  - `ap_done`=`ap_ready`=1 for exactly this cycle.
  - Unconditionally go to IDLE.
  - `ap_start` is ignored in DONE; the control slave drops it on `ap_ready`.
- Framing check: `err_tlast` is set on any A or B handshake where `tlast` ≠ (that stream's counter == `len_r`−1). Once set, it holds until the next accepted start.
- Counter arithmetic:
  - Unsigned; `len_r`−1 is computed in C_LEN_WIDTH bits.
  - Maximum run length is 2^C_LEN_WIDTH−1. Counters never wrap, because enables drop at `len_r`.

## Timing
- Reset values:
  - state=IDLE, `ap_idle`=1, `ap_done`=0, `ap_ready`=0, `err_tlast`=0, counters=0.
  - All `tvalid` outputs and `tready` outputs are 0.
- Start latency: the start is accepted at edge N, so gates are open in cycle N+1. The first beat can complete in the first RUN cycle.
- `ap_idle` falls in the cycle after acceptance and rises in the cycle after the `ap_done` pulse.
- `ap_done` is asserted in the cycle after the final C handshake.
- Zero-length run: `ap_done` is asserted one cycle after acceptance, and no beats are moved.
- Back-to-back runs:
  - Minimum 3 cycles of control overhead per run: accept, DONE, IDLE.
  - The IDLE cycle after DONE is required, even if `ap_start` is still high there.
- Handshake rules:
  - The gates are combinational from registered state only; there is no combinational path from `tready` to `tvalid` on the same side.
  - Beats beyond `len_r` are stalled (`tready`=0), never dropped.
- Simultaneous A, B and C handshakes in one cycle each count independently.
- Reset mid-run:
  - The next cycle is IDLE with all gates closed.
  - In-flight adder contents are not flushed by this block.
  - Upstream beats stay pending.

## Test plan
- Reset, then `length`=4, A=B={1.0,2.0,3.0,4.0} with correct `tlast`, sinks always ready -> C={2.0,4.0,6.0,8.0}; `tlast` only on beat 3; `ap_done` one cycle after the last C beat; `err_tlast`=0.
- `length`=3 with 5 beats offered on A and B -> exactly 3 pass; `s_axis_a_tready`/`s_axis_b_tready` stay 0 afterwards; the fourth beat remains pending with `tvalid`=1; `ap_idle` returns to 1.
- `length`=0 -> `ap_done` pulses 1 cycle after the start is accepted; no `tvalid` on any downstream port.
- `length`=4 with random `m_axis_c_tready` (50%) and B delayed 3 cycles behind A -> 4 correct results in order; `m_axis_c_tvalid` held stable while stalled; `cnt_a` leads `cnt_b` by up to 3.
- `length`=4 with upstream A `tlast` on beat 1 -> `err_tlast`=1 after that beat, held through DONE; the run still completes 4 beats; the next start clears `err_tlast`.
- Assert `ap_areset` after 2 of 6 results -> next cycle: `ap_idle`=1, all `tready`=0; a fresh `length`=2 run then completes normally.

Source files
------------

// File: rtl/vadd_float_sequencer.sv
// Run-length sequencer between the kernel AXI4-Stream ports and vadd_float_adder.
// Admits exactly `length` operand beats per run, frames the result stream and reports upstream tlast errors.
module vadd_float_sequencer #(
  parameter int C_AXIS_TDATA_WIDTH = 32,
  parameter int C_LEN_WIDTH        = 32
) (
  input  logic                              ap_aclk,
  input  logic                              ap_areset,
  input  logic                              ap_start,
  input  logic [C_LEN_WIDTH-1:0]            length,
  output logic                              ap_idle,
  output logic                              ap_done,
  output logic                              ap_ready,
  output logic                              err_tlast,

  input  logic                              s_axis_a_tvalid,
  output logic                              s_axis_a_tready,
  input  logic [C_AXIS_TDATA_WIDTH-1:0]     s_axis_a_tdata,
  input  logic [C_AXIS_TDATA_WIDTH/8-1:0]   s_axis_a_tkeep,
  input  logic                              s_axis_a_tlast,

  input  logic                              s_axis_b_tvalid,
  output logic                              s_axis_b_tready,
  input  logic [C_AXIS_TDATA_WIDTH-1:0]     s_axis_b_tdata,
  input  logic [C_AXIS_TDATA_WIDTH/8-1:0]   s_axis_b_tkeep,
  input  logic                              s_axis_b_tlast,

  output logic                              m_axis_a_tvalid,
  input  logic                              m_axis_a_tready,
  output logic [C_AXIS_TDATA_WIDTH-1:0]     m_axis_a_tdata,
  output logic [C_AXIS_TDATA_WIDTH/8-1:0]   m_axis_a_tkeep,
  output logic                              m_axis_a_tlast,

  output logic                              m_axis_b_tvalid,
  input  logic                              m_axis_b_tready,
  output logic [C_AXIS_TDATA_WIDTH-1:0]     m_axis_b_tdata,
  output logic [C_AXIS_TDATA_WIDTH/8-1:0]   m_axis_b_tkeep,
  output logic                              m_axis_b_tlast,

  input  logic                              s_axis_c_tvalid,
  output logic                              s_axis_c_tready,
  input  logic [C_AXIS_TDATA_WIDTH-1:0]     s_axis_c_tdata,
  input  logic [C_AXIS_TDATA_WIDTH/8-1:0]   s_axis_c_tkeep,
  input  logic                              s_axis_c_tlast,

  output logic                              m_axis_c_tvalid,
  input  logic                              m_axis_c_tready,
  output logic [C_AXIS_TDATA_WIDTH-1:0]     m_axis_c_tdata,
  output logic [C_AXIS_TDATA_WIDTH/8-1:0]   m_axis_c_tkeep,
  output logic                              m_axis_c_tlast
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] RUN  = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  localparam logic [C_LEN_WIDTH-1:0] ONE = {{(C_LEN_WIDTH-1){1'b0}}, 1'b1};

  logic [1:0]             state;
  logic [C_LEN_WIDTH-1:0] len_r;
  logic [C_LEN_WIDTH-1:0] len_last;
  logic [C_LEN_WIDTH-1:0] cnt_a;
  logic [C_LEN_WIDTH-1:0] cnt_b;
  logic [C_LEN_WIDTH-1:0] cnt_c;
  logic                   running;
  logic                   en_a;
  logic                   en_b;
  logic                   en_c;
  logic                   hs_a;
  logic                   hs_b;
  logic                   hs_c;
  logic                   last_c;
  logic                   bad_a;
  logic                   bad_b;
  logic                   unused_c_tlast;

  // The adder's own tlast carries no framing we trust; the result frame comes from cnt_c.
  assign unused_c_tlast = s_axis_c_tlast;

  assign running  = (state == RUN);
  assign len_last = len_r - ONE;

  assign en_a = running && (cnt_a < len_r);
  assign en_b = running && (cnt_b < len_r);
  assign en_c = running && (cnt_c < len_r);

  assign m_axis_a_tvalid = s_axis_a_tvalid & en_a;
  assign s_axis_a_tready = m_axis_a_tready & en_a;
  assign m_axis_a_tdata  = s_axis_a_tdata;
  assign m_axis_a_tkeep  = s_axis_a_tkeep;
  assign m_axis_a_tlast  = s_axis_a_tlast;

  assign m_axis_b_tvalid = s_axis_b_tvalid & en_b;
  assign s_axis_b_tready = m_axis_b_tready & en_b;
  assign m_axis_b_tdata  = s_axis_b_tdata;
  assign m_axis_b_tkeep  = s_axis_b_tkeep;
  assign m_axis_b_tlast  = s_axis_b_tlast;

  assign m_axis_c_tvalid = s_axis_c_tvalid & en_c;
  assign s_axis_c_tready = m_axis_c_tready & en_c;
  assign m_axis_c_tdata  = s_axis_c_tdata;
  assign m_axis_c_tkeep  = s_axis_c_tkeep;
  assign last_c          = (cnt_c == len_last);
  assign m_axis_c_tlast  = last_c;

  assign hs_a = s_axis_a_tvalid & s_axis_a_tready;
  assign hs_b = s_axis_b_tvalid & s_axis_b_tready;
  assign hs_c = s_axis_c_tvalid & s_axis_c_tready;

  // An operand beat is misframed when its tlast disagrees with its position in the run.
  assign bad_a = hs_a && (s_axis_a_tlast != (cnt_a == len_last));
  assign bad_b = hs_b && (s_axis_b_tlast != (cnt_b == len_last));

  assign ap_idle  = (state == IDLE);
  assign ap_done  = (state == DONE);
  assign ap_ready = ap_done;

  always_ff @(posedge ap_aclk) begin
    if (ap_areset) begin
      state     <= IDLE;
      len_r     <= '0;
      cnt_a     <= '0;
      cnt_b     <= '0;
      cnt_c     <= '0;
      err_tlast <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (ap_start) begin
            err_tlast <= 1'b0;
            if (length != '0) begin
              len_r <= length;
              cnt_a <= '0;
              cnt_b <= '0;
              cnt_c <= '0;
              state <= RUN;
            end else begin
              state <= DONE;
            end
          end
        end
        RUN: begin
          if (hs_a) cnt_a <= cnt_a + ONE;
          if (hs_b) cnt_b <= cnt_b + ONE;
          if (hs_c) cnt_c <= cnt_c + ONE;
          if (bad_a || bad_b) err_tlast <= 1'b1;
          if (hs_c && last_c) state <= DONE;
        end
        DONE: state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule
